// File: rtl/hwag_angle_counter.sv
// Crank-angle generator: measures tooth periods, locks on the missing-tooth gap and interpolates angle between edges.
// Optional build macro HWAG_ANGLE_TIMEOUT_EN: a saturated tooth-period counter drops the engine back to IDLE.
module hwag_angle_counter #(
  parameter int TOOTH_WIDTH = 24,
  parameter int ANGLE_WIDTH = 24,
  parameter int TEETH       = 60,
  parameter int GAP         = 2,
  parameter int SUB_SHIFT   = 6
) (
  input  logic                   clk,
  input  logic                   arst_n,
  input  logic                   ena,
  input  logic                   cap,
  output logic [ANGLE_WIDTH-1:0] angle,
  output logic                   angle_tick,
  output logic [7:0]             tooth,
  output logic [TOOTH_WIDTH-1:0] last_period,
  output logic                   sync,
  output logic                   gap_pulse,
  output logic                   err
);
  localparam int               SUB_W      = $clog2((GAP + 1) << SUB_SHIFT);
  localparam logic [7:0]       LAST_TOOTH = 8'(TEETH - GAP - 1);
  localparam logic [SUB_W-1:0] SUB_LIM_N  = SUB_W'((1 << SUB_SHIFT) - 1);
  localparam logic [SUB_W-1:0] SUB_LIM_G  = SUB_W'(((GAP + 1) << SUB_SHIFT) - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEEK = 2'd1,
    S_LOCK = 2'd2
  } state_t;

  state_t                 r_state;
  logic [TOOTH_WIDTH-1:0] r_period_cnt;
  logic [TOOTH_WIDTH-1:0] r_last_period;
  logic [TOOTH_WIDTH-1:0] r_div;
  logic [SUB_W-1:0]       r_sub;
  logic [ANGLE_WIDTH-1:0] r_angle;
  logic [7:0]             r_tooth;
  logic                   r_tick;
  logic                   r_sync;
  logic                   r_gap_pulse;
  logic                   r_err;

  logic [TOOTH_WIDTH:0]   w_gap_thresh;
  logic                   w_gap;
  logic                   w_cnt_sat;
  logic                   w_last_tooth;
  logic [TOOTH_WIDTH-1:0] w_step;
  logic [TOOTH_WIDTH-1:0] w_step_m1;
  logic [SUB_W-1:0]       w_sub_lim;
  logic [ANGLE_WIDTH-1:0] w_jump_angle;

  // r_period_cnt holds the period of the tooth that ends on this cap
  assign w_gap_thresh = {1'b0, r_last_period} + {2'b00, r_last_period[TOOTH_WIDTH-1:1]};
  assign w_gap        = {1'b0, r_period_cnt} > w_gap_thresh;
  assign w_cnt_sat    = (r_period_cnt == '1);
  assign w_last_tooth = (r_tooth == LAST_TOOTH);
  assign w_step       = r_last_period >> SUB_SHIFT;
  assign w_step_m1    = (w_step == '0) ? '0 : w_step - TOOTH_WIDTH'(1);
  assign w_sub_lim    = w_last_tooth ? SUB_LIM_G : SUB_LIM_N;
  assign w_jump_angle = ANGLE_WIDTH'(r_tooth + 8'd1) << SUB_SHIFT;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_state       <= S_IDLE;
      r_period_cnt  <= '0;
      r_last_period <= '0;
      r_div         <= '0;
      r_sub         <= '0;
      r_angle       <= '0;
      r_tooth       <= '0;
      r_tick        <= 1'b0;
      r_sync        <= 1'b0;
      r_gap_pulse   <= 1'b0;
      r_err         <= 1'b0;
    end else if (!ena) begin
      r_tick      <= 1'b0;
      r_gap_pulse <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_tick      <= 1'b0;
      r_gap_pulse <= 1'b0;
      r_err       <= 1'b0;
      if (cap) begin
        r_period_cnt <= TOOTH_WIDTH'(1);
      end else if (!w_cnt_sat) begin
        r_period_cnt <= r_period_cnt + TOOTH_WIDTH'(1);
      end

      if (cap) begin
        // an edge always wins over a coinciding divider expiry
        r_div <= '0;
        r_sub <= '0;
        case (r_state)
          S_IDLE: begin
            r_state       <= S_SEEK;
            r_last_period <= r_period_cnt;
          end
          S_SEEK: begin
            if (w_gap) begin
              r_state     <= S_LOCK;
              r_sync      <= 1'b1;
              r_tooth     <= '0;
              r_angle     <= '0;
              r_gap_pulse <= 1'b1;
            end else begin
              r_last_period <= r_period_cnt;
            end
          end
          S_LOCK: begin
            if (!w_gap) begin
              r_last_period <= r_period_cnt;
            end
            if (w_gap && w_last_tooth) begin
              r_tooth     <= '0;
              r_angle     <= '0;
              r_tick      <= (r_angle != '0);
              r_gap_pulse <= 1'b1;
            end else if (!w_gap && !w_last_tooth) begin
              r_tooth <= r_tooth + 8'd1;
              r_angle <= w_jump_angle;
              r_tick  <= (w_jump_angle != r_angle);
            end else begin
              r_state <= S_SEEK;
              r_sync  <= 1'b0;
              r_err   <= 1'b1;
              r_tooth <= '0;
              r_angle <= '0;
              r_tick  <= (r_angle != '0);
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
`ifdef HWAG_ANGLE_TIMEOUT_EN
      else if (w_cnt_sat) begin
        r_err   <= (r_state == S_LOCK);
        r_state <= S_IDLE;
        r_sync  <= 1'b0;
        r_tooth <= '0;
        r_angle <= '0;
        r_div   <= '0;
        r_sub   <= '0;
        r_tick  <= (r_angle != '0);
      end
`endif
      else if (r_state == S_LOCK) begin
        // sub-ticks stop at the tooth limit so angle never runs into the next tooth
        if (r_div == w_step_m1) begin
          r_div <= '0;
          if (r_sub < w_sub_lim) begin
            r_sub   <= r_sub + SUB_W'(1);
            r_angle <= r_angle + ANGLE_WIDTH'(1);
            r_tick  <= 1'b1;
          end
        end else begin
          r_div <= r_div + TOOTH_WIDTH'(1);
        end
      end
    end
  end

  assign angle       = r_angle;
  assign angle_tick  = r_tick;
  assign tooth       = r_tooth;
  assign last_period = r_last_period;
  assign sync        = r_sync;
  assign gap_pulse   = r_gap_pulse;
  assign err         = r_err;

endmodule

// File: tb/tb_hwag_angle_counter.sv
// Bench for hwag_angle_counter: per-cycle reference model plus table vectors and hand-written corner sequences.
`timescale 1ns/1ps
module tb_hwag_angle_counter;
  localparam int TW      = 12;
  localparam int AW      = 24;
  localparam int TEETH   = 60;
  localparam int GAP     = 2;
  localparam int SS      = 6;
  localparam int REAL    = TEETH - GAP;
  localparam int SUBS    = 1 << SS;
  localparam int CNT_MAX = (1 << TW) - 1;
  localparam int M_IDLE  = 0;
  localparam int M_SEEK  = 1;
  localparam int M_LOCK  = 2;

  logic          clk = 1'b0;
  logic          arst_n;
  logic          ena;
  logic          cap;
  logic [AW-1:0] angle;
  logic          angle_tick;
  logic [7:0]    tooth;
  logic [TW-1:0] last_period;
  logic          sync;
  logic          gap_pulse;
  logic          err;

  always #5 clk = ~clk;

  hwag_angle_counter #(
    .TOOTH_WIDTH(TW), .ANGLE_WIDTH(AW), .TEETH(TEETH), .GAP(GAP), .SUB_SHIFT(SS)
  ) dut (
    .clk(clk), .arst_n(arst_n), .ena(ena), .cap(cap),
    .angle(angle), .angle_tick(angle_tick), .tooth(tooth), .last_period(last_period),
    .sync(sync), .gap_pulse(gap_pulse), .err(err)
  );

  int n_checks = 0;
  int n_err    = 0;
  int err_seen = 0;

  // reference model: position = tooth index plus elapsed time since the last edge
  int m_state, m_cnt, m_lp, m_tooth, m_since, exp_angle, prev_angle;
  bit exp_tick, exp_gp, exp_err;

  typedef struct {
    int len;
    int tooth;
    bit sync;
    bit gp;
    bit er;
    int ang;
  } vec_t;
  vec_t tbl[9];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, got, want, $time);
    end
  endtask

  task automatic model_reset();
    m_state = M_IDLE; m_cnt = 0; m_lp = 0; m_tooth = 0; m_since = 0;
    exp_angle = 0; prev_angle = 0; exp_tick = 0; exp_gp = 0; exp_err = 0;
  endtask

  task automatic model_step(input bit c, input bit e);
    int cp, step, lim, sub;
    bit g;
    exp_gp  = 0;
    exp_err = 0;
    if (e) begin
      cp = m_cnt;
      if (c) m_cnt = 1;
      else if (m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
      if (c) begin
        g = (2 * cp > 3 * m_lp);
        if (m_state == M_IDLE) begin
          m_state = M_SEEK;
          m_lp    = cp;
        end else if (g) begin
          if (m_state == M_SEEK || m_tooth == REAL - 1) begin
            m_state = M_LOCK; m_tooth = 0; m_since = 0; exp_gp = 1;
          end else begin
            m_state = M_SEEK; m_tooth = 0; exp_err = 1;
          end
        end else begin
          m_lp = cp;
          if (m_state == M_LOCK) begin
            if (m_tooth < REAL - 1) begin
              m_tooth = m_tooth + 1; m_since = 0;
            end else begin
              m_state = M_SEEK; m_tooth = 0; exp_err = 1;
            end
          end
        end
      end
`ifdef HWAG_ANGLE_TIMEOUT_EN
      else if (cp == CNT_MAX) begin
        if (m_state == M_LOCK) exp_err = 1;
        m_state = M_IDLE; m_tooth = 0;
      end
`endif
      else if (m_state == M_LOCK) begin
        m_since = m_since + 1;
      end
    end
    step = m_lp / SUBS;
    if (step == 0) step = 1;
    lim  = (m_tooth == REAL - 1) ? (GAP + 1) * SUBS - 1 : SUBS - 1;
    sub  = m_since / step;
    if (sub > lim) sub = lim;
    exp_angle  = (m_state == M_LOCK) ? m_tooth * SUBS + sub : 0;
    exp_tick   = (exp_angle != prev_angle);
    prev_angle = exp_angle;
  endtask

  task automatic cmp_model();
    chk("m_angle", angle, exp_angle);
    chk("m_tick", angle_tick, exp_tick);
    chk("m_tooth", tooth, m_tooth);
    chk("m_sync", sync, (m_state == M_LOCK));
    chk("m_gap_pulse", gap_pulse, exp_gp);
    chk("m_err", err, exp_err);
    chk("m_last_period", last_period, m_lp);
  endtask

  task automatic cyc(input bit c);
    cap = c;
    @(posedge clk);
    model_step(c, ena);
    @(negedge clk);
    cmp_model();
    if (err) err_seen++;
  endtask

  task automatic run_tooth(input int len);
    repeat (len - 1) cyc(1'b0);
    cyc(1'b1);
  endtask

  task automatic do_reset();
    cap    = 1'b0;
    arst_n = 1'b0;
    #1;
    chk("rst_angle", angle, 0);
    chk("rst_tick", angle_tick, 0);
    chk("rst_tooth", tooth, 0);
    chk("rst_last_period", last_period, 0);
    chk("rst_sync", sync, 0);
    chk("rst_gap_pulse", gap_pulse, 0);
    chk("rst_err", err, 0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    arst_n = 1'b1;
  endtask

  initial begin
    tbl[0] = '{128, 0, 1'b0, 1'b0, 1'b0, 0};
    tbl[1] = '{128, 0, 1'b0, 1'b0, 1'b0, 0};
    tbl[2] = '{384, 0, 1'b1, 1'b1, 1'b0, 0};
    tbl[3] = '{128, 1, 1'b1, 1'b0, 1'b0, 64};
    tbl[4] = '{128, 2, 1'b1, 1'b0, 1'b0, 128};
    tbl[5] = '{384, 0, 1'b0, 1'b0, 1'b1, 0};
    tbl[6] = '{128, 0, 1'b0, 1'b0, 1'b0, 0};
    tbl[7] = '{384, 0, 1'b1, 1'b1, 1'b0, 0};
    tbl[8] = '{128, 1, 1'b1, 1'b0, 1'b0, 64};

    arst_n = 1'b1; ena = 1'b1; cap = 1'b0;
    #2;
    do_reset();

    for (int i = 0; i < 9; i++) begin
      run_tooth(tbl[i].len);
      chk($sformatf("tbl%0d_tooth", i), tooth, tbl[i].tooth);
      chk($sformatf("tbl%0d_sync", i), sync, tbl[i].sync);
      chk($sformatf("tbl%0d_gap_pulse", i), gap_pulse, tbl[i].gp);
      chk($sformatf("tbl%0d_err", i), err, tbl[i].er);
      chk($sformatf("tbl%0d_angle", i), angle, tbl[i].ang);
    end

    // full revolution at 640 clk/tooth, 1920 across the gap
    do_reset();
    run_tooth(640);
    run_tooth(640);
    run_tooth(1920);
    chk("lock_sync", sync, 1);
    chk("lock_gap_pulse", gap_pulse, 1);
    for (int t = 1; t < REAL; t++) run_tooth(640);
    chk("t57_start", angle, 3648);
    repeat (1919) cyc(1'b0);
    chk("t57_end", angle, 3839);
    cyc(1'b1);
    chk("wrap_angle", angle, 0);
    chk("wrap_gap_pulse", gap_pulse, 1);
    chk("wrap_tick", angle_tick, 1);
    repeat (10) cyc(1'b0);
    chk("interp_1", angle, 1);
    repeat (9) cyc(1'b0);
    chk("interp_hold", angle, 1);
    cyc(1'b0);
    chk("interp_2", angle, 2);
    repeat (619) cyc(1'b0);
    cyc(1'b1);
    chk("tooth1_angle", angle, 64);

    // deceleration: slow but non-gap tooth stalls at the tooth limit
    repeat (899) cyc(1'b0);
    chk("decel_stall", angle, 127);
    cyc(1'b1);
    chk("decel_jump", angle, 128);

    // edge coinciding with divider expiry
    run_tooth(640);
    chk("t3_angle", angle, 192);
    repeat (599) cyc(1'b0);
    chk("pre_collision", angle, 251);
    cyc(1'b1);
    chk("collision_angle", angle, 256);
    chk("collision_tick", angle_tick, 1);
    cyc(1'b0);
    chk("collision_single_tick", angle_tick, 0);
    chk("collision_hold", angle, 256);

    // edges stop while locked
    err_seen = 0;
    repeat (4200) cyc(1'b0);
`ifdef HWAG_ANGLE_TIMEOUT_EN
    chk("stall_sync", sync, 0);
    chk("stall_err_count", err_seen, 1);
    chk("stall_angle", angle, 0);
`else
    chk("stall_sync", sync, 1);
    chk("stall_err_count", err_seen, 0);
    chk("stall_angle", angle, 319);
`endif

    // asynchronous reset in the middle of a locked revolution
    do_reset();
    run_tooth(128);
    run_tooth(128);
    run_tooth(384);
    run_tooth(128);
    repeat (50) cyc(1'b0);
    chk("pre_reset_sync", sync, 1);
    do_reset();
    run_tooth(128);
    chk("post_reset_sync", sync, 0);
    chk("post_reset_tooth", tooth, 0);

    // randomized wheel with jitter, stray gaps and enable drop-outs
    do_reset();
    for (int k = 0; k < 150; k++) begin
      int len;
      if ((k % REAL) == REAL - 1 || $urandom_range(0, 39) == 0)
        len = int'($urandom_range(300, 340));
      else
        len = int'($urandom_range(96, 112));
      repeat (len - 1) begin
        ena = ($urandom_range(0, 31) != 0);
        cyc(1'b0);
      end
      ena = ($urandom_range(0, 31) != 0);
      cyc(1'b1);
    end
    ena = 1'b1;
    cyc(1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
